// File: rtl/snn_weight_mem_if.sv
// Request/return bundle for snn_weight_mem.
//   master: weight-load controller / accumulators. It drives the requests and receives the returns.
//   slave : the memory itself.
// Port A: a_req, a_we, a_addr, a_wdata -> a_rvalid, a_rdata, a_oob (read/write).
// Port B: b_req, b_addr                -> b_rvalid, b_rdata, b_oob (read-only).
interface snn_weight_mem_if #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 33
) ();
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;
    logic              a_oob;

    logic              b_req;
    logic [ADDR_W-1:0] b_addr;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;
    logic              b_oob;

    modport master (
        output a_req, a_we, a_addr, a_wdata, b_req, b_addr,
        input  a_rvalid, a_rdata, a_oob, b_rvalid, b_rdata, b_oob
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata, b_req, b_addr,
        output a_rvalid, a_rdata, a_oob, b_rvalid, b_rdata, b_oob
    );
endinterface

// File: rtl/snn_weight_mem.sv
// Dual-port synaptic weight memory.
// Port A reads or writes, and port B only reads. Both ports accept one request every cycle.
// Read data returns RD_LAT (1 or 2) cycles after issue, with an rvalid pulse.
// An address >= DEPTH is out of range: its read returns 0, its write is dropped,
// and the port's oob output pulses in the cycle where the rvalid would appear.
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset (memory contents kept)
//   bus_io : request/return bundle (slave side)
module snn_weight_mem #(
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned DATA_W    = 33,
    parameter int unsigned DEPTH     = 8192,
    parameter int unsigned RD_LAT    = 2,
    parameter string       INIT_FILE = ""
) (
    input  logic            clk_i,
    input  logic            rst_i,
    snn_weight_mem_if.slave bus_io
);
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Request decode. Nothing is accepted while rst_i is high.
    logic              a_acc, a_oob, a_rd, a_wr;
    logic              b_acc, b_oob;
    logic [IdxW-1:0]   a_idx, b_idx;
    logic [DATA_W-1:0] a_look, b_look;

    always_comb begin
        a_acc  = ~rst_i & bus_io.a_req;
        a_oob  = a_acc & (32'(bus_io.a_addr) >= DEPTH);
        a_rd   = a_acc & ~bus_io.a_we;
        a_wr   = a_acc & bus_io.a_we & ~a_oob;
        a_idx  = bus_io.a_addr[IdxW-1:0];
        a_look = a_oob ? '0 : mem_q[a_idx];

        b_acc  = ~rst_i & bus_io.b_req;
        b_oob  = b_acc & (32'(bus_io.b_addr) >= DEPTH);
        b_idx  = bus_io.b_addr[IdxW-1:0];
        b_look = b_oob ? '0 : mem_q[b_idx];
    end

    // The read data registers below capture the old word at the same edge, so a
    // same-cycle collision reads first.
    always_ff @(posedge clk_i) begin
        if (a_wr) begin
            mem_q[a_idx] <= bus_io.a_wdata;
        end
    end

    // Valid/oob shift registers. Write-side oob travels the same path so that it lines up
    // with the cycle where a read would have returned.
    logic [RD_LAT-1:0] a_vld_q, a_oobp_q, b_vld_q, b_oobp_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_vld_q  <= '0;
            a_oobp_q <= '0;
            b_vld_q  <= '0;
            b_oobp_q <= '0;
        end else begin
            a_vld_q[0]  <= a_rd;
            a_oobp_q[0] <= a_oob;
            b_vld_q[0]  <= b_acc;
            b_oobp_q[0] <= b_oob;
            for (int i = 1; i < RD_LAT; i++) begin
                a_vld_q[i]  <= a_vld_q[i-1];
                a_oobp_q[i] <= a_oobp_q[i-1];
                b_vld_q[i]  <= b_vld_q[i-1];
                b_oobp_q[i] <= b_oobp_q[i-1];
            end
        end
    end

    // Output data registers load only on a returning read, so rdata holds between returns.
    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

    if (RD_LAT == 1) begin : g_lat1
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                a_rdata_q <= '0;
                b_rdata_q <= '0;
            end else begin
                if (a_rd)  a_rdata_q <= a_look;
                if (b_acc) b_rdata_q <= b_look;
            end
        end
    end else begin : g_lat2
        // Stands in for the BRAM output register. Its contents only matter when stage 0 is valid.
        logic [DATA_W-1:0] a_d1_q, b_d1_q;

        always_ff @(posedge clk_i) begin
            if (a_rd)  a_d1_q <= a_look;
            if (b_acc) b_d1_q <= b_look;
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                a_rdata_q <= '0;
                b_rdata_q <= '0;
            end else begin
                if (a_vld_q[0]) a_rdata_q <= a_d1_q;
                if (b_vld_q[0]) b_rdata_q <= b_d1_q;
            end
        end
    end

    assign bus_io.a_rvalid = a_vld_q[RD_LAT-1];
    assign bus_io.a_oob    = a_oobp_q[RD_LAT-1];
    assign bus_io.a_rdata  = a_rdata_q;
    assign bus_io.b_rvalid = b_vld_q[RD_LAT-1];
    assign bus_io.b_oob    = b_oobp_q[RD_LAT-1];
    assign bus_io.b_rdata  = b_rdata_q;
endmodule

// File: tb/tb_snn_weight_mem.sv
// Bench for snn_weight_mem. Two instances get identical stimulus:
//   dut 0: DEPTH=4000, RD_LAT=2
//   dut 1: DEPTH=8192, RD_LAT=1
// A reference model checks every output after every edge. The model keeps an array copy of
// the memory and a queue of pending returns for each port, each tagged with the cycle it is due.
module tb_snn_weight_mem;
    localparam int unsigned AW = 13;
    localparam int unsigned DW = 33;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_r;
    logic          a_req_r, a_we_r, b_req_r;
    logic [AW-1:0] a_addr_r, b_addr_r;
    logic [DW-1:0] a_wdata_r;

    snn_weight_mem_if #(.ADDR_W(AW), .DATA_W(DW)) if_d0 ();
    snn_weight_mem_if #(.ADDR_W(AW), .DATA_W(DW)) if_d1 ();

    assign if_d0.a_req   = a_req_r;
    assign if_d0.a_we    = a_we_r;
    assign if_d0.a_addr  = a_addr_r;
    assign if_d0.a_wdata = a_wdata_r;
    assign if_d0.b_req   = b_req_r;
    assign if_d0.b_addr  = b_addr_r;
    assign if_d1.a_req   = a_req_r;
    assign if_d1.a_we    = a_we_r;
    assign if_d1.a_addr  = a_addr_r;
    assign if_d1.a_wdata = a_wdata_r;
    assign if_d1.b_req   = b_req_r;
    assign if_d1.b_addr  = b_addr_r;

    snn_weight_mem #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(4000), .RD_LAT(2), .INIT_FILE("")
    ) u_dut0 (
        .clk_i  (clk),
        .rst_i  (rst_r),
        .bus_io (if_d0)
    );

    snn_weight_mem #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(8192), .RD_LAT(1), .INIT_FILE("")
    ) u_dut1 (
        .clk_i  (clk),
        .rst_i  (rst_r),
        .bus_io (if_d1)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned   due;
        logic          vld;
        logic          oob;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          pend_q [4][$];      // index = 2*dut + port (0 = A, 1 = B)
    logic [DW-1:0] ref_mem [2][8192];
    logic          exp_vld [4];
    logic          exp_oob [4];
    logic [DW-1:0] exp_data [4];
    int unsigned   cyc_n;
    int            n_cmp;
    int            n_err;

    function automatic int unsigned depth_of(input int k);
        return (k == 0) ? 4000 : 8192;
    endfunction

    function automatic int unsigned lat_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc_n, got, exp);
        end
    endtask

    // Apply the requests sampled at this edge, then work out which returns are visible after it.
    task automatic model_edge();
        ret_t        e;
        logic        oob;
        int unsigned due;
        cyc_n++;
        for (int k = 0; k < 2; k++) begin
            if (rst_r) begin
                for (int p = 0; p < 2; p++) begin
                    pend_q[2*k+p].delete();
                    exp_vld[2*k+p]  = 1'b0;
                    exp_oob[2*k+p]  = 1'b0;
                    exp_data[2*k+p] = '0;
                end
            end else begin
                due = cyc_n + lat_of(k) - 1;
                if (b_req_r) begin
                    oob    = (32'(b_addr_r) >= depth_of(k));
                    e.due  = due;
                    e.vld  = 1'b1;
                    e.oob  = oob;
                    e.data = oob ? '0 : ref_mem[k][b_addr_r];
                    pend_q[2*k+1].push_back(e);
                end
                if (a_req_r) begin
                    oob    = (32'(a_addr_r) >= depth_of(k));
                    e.due  = due;
                    e.vld  = ~a_we_r;
                    e.oob  = oob;
                    e.data = (oob || a_we_r) ? '0 : ref_mem[k][a_addr_r];
                    if (e.vld || e.oob) pend_q[2*k].push_back(e);
                    // The update comes after port B's lookup above, so a collision reads the old word.
                    if (a_we_r && !oob) ref_mem[k][a_addr_r] = a_wdata_r;
                end
                for (int p = 0; p < 2; p++) begin
                    exp_vld[2*k+p] = 1'b0;
                    exp_oob[2*k+p] = 1'b0;
                    if (pend_q[2*k+p].size() > 0) begin
                        e = pend_q[2*k+p][0];
                        if (e.due == cyc_n) begin
                            void'(pend_q[2*k+p].pop_front());
                            exp_vld[2*k+p] = e.vld;
                            exp_oob[2*k+p] = e.oob;
                            if (e.vld) exp_data[2*k+p] = e.data;
                        end
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("d0.a_rvalid", 64'(if_d0.a_rvalid), 64'(exp_vld[0]));
        check_eq("d0.a_oob",    64'(if_d0.a_oob),    64'(exp_oob[0]));
        check_eq("d0.a_rdata",  64'(if_d0.a_rdata),  64'(exp_data[0]));
        check_eq("d0.b_rvalid", 64'(if_d0.b_rvalid), 64'(exp_vld[1]));
        check_eq("d0.b_oob",    64'(if_d0.b_oob),    64'(exp_oob[1]));
        check_eq("d0.b_rdata",  64'(if_d0.b_rdata),  64'(exp_data[1]));
        check_eq("d1.a_rvalid", 64'(if_d1.a_rvalid), 64'(exp_vld[2]));
        check_eq("d1.a_oob",    64'(if_d1.a_oob),    64'(exp_oob[2]));
        check_eq("d1.a_rdata",  64'(if_d1.a_rdata),  64'(exp_data[2]));
        check_eq("d1.b_rvalid", 64'(if_d1.b_rvalid), 64'(exp_vld[3]));
        check_eq("d1.b_oob",    64'(if_d1.b_oob),    64'(exp_oob[3]));
        check_eq("d1.b_rdata",  64'(if_d1.b_rdata),  64'(exp_data[3]));
    endtask

    // One clock cycle: inputs are driven at the negedge, the model steps at the posedge,
    // and the DUT outputs are checked 1 time unit later.
    task automatic cyc(input logic rst, input logic ar, input logic aw, input int unsigned aa,
                       input logic [DW-1:0] ad, input logic br, input int unsigned ba);
        rst_r     = rst;
        a_req_r   = ar;
        a_we_r    = aw;
        a_addr_r  = AW'(aa);
        a_wdata_r = ad;
        b_req_r   = br;
        b_addr_r  = AW'(ba);
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 0);
    endtask

    function automatic int unsigned rand_addr();
        case ($urandom_range(0, 3))
            0:       return $urandom_range(0, 15);
            1:       return $urandom_range(3990, 4010);
            2:       return $urandom_range(8180, 8191);
            default: return $urandom_range(0, 8191);
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL timeout cycle=%0d", cyc_n);
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc_n = 0;
        for (int p = 0; p < 4; p++) begin
            exp_vld[p]  = 1'b0;
            exp_oob[p]  = 1'b0;
            exp_data[p] = '0;
        end
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8192; i++) ref_mem[k][i] = '0;
        rst_r = 1'b1; a_req_r = 1'b0; a_we_r = 1'b0; b_req_r = 1'b0;
        a_addr_r = '0; b_addr_r = '0; a_wdata_r = '0;
        @(negedge clk);

        // Reset state. These requests must be dropped.
        cyc(1'b1, 1'b0, 1'b0, 0, '0, 1'b0, 0);
        cyc(1'b1, 1'b1, 1'b1, 3, 33'h1AA, 1'b1, 3);

        // Preload every word with its own index through port A.
        for (int i = 0; i < 8192; i++) cyc(1'b0, 1'b1, 1'b1, i, DW'(i), 1'b0, 0);
        idle(2);

        // Streaming reads on both ports.
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, i, '0, 1'b1, i);
        idle(3);

        // Load then read on the other port.
        cyc(1'b0, 1'b1, 1'b1, 5, 33'h1_0000_00AB, 1'b0, 0);
        cyc(1'b0, 1'b0, 1'b0, 0, '0, 1'b1, 5);
        idle(3);

        // Collision: B reads the old word, then the new one.
        cyc(1'b0, 1'b1, 1'b1, 7, 33'h11, 1'b0, 0);
        idle(1);
        cyc(1'b0, 1'b1, 1'b1, 7, 33'h22, 1'b1, 7);
        cyc(1'b0, 1'b0, 1'b0, 0, '0, 1'b1, 7);
        idle(3);

        // Out of range for dut 0. Address 95 (4095 mod 4000) must keep its preload.
        cyc(1'b0, 1'b0, 1'b0, 0, '0, 1'b1, 4000);
        idle(2);
        cyc(1'b0, 1'b1, 1'b1, 4095, 33'h3F, 1'b0, 0);
        cyc(1'b0, 1'b1, 1'b0, 4095, '0, 1'b1, 95);
        idle(3);

        // Reset in the middle of a read stream.
        cyc(1'b0, 1'b1, 1'b0, 20, '0, 1'b1, 21);
        cyc(1'b0, 1'b1, 1'b0, 21, '0, 1'b1, 22);
        cyc(1'b1, 1'b1, 1'b0, 22, '0, 1'b1, 23);
        cyc(1'b0, 1'b1, 1'b0, 23, '0, 1'b1, 24);
        idle(3);

        // Hold: rdata keeps 0x55 through a long idle stretch.
        cyc(1'b0, 1'b1, 1'b1, 9, 33'h55, 1'b0, 0);
        cyc(1'b0, 1'b1, 1'b0, 9, '0, 1'b0, 0);
        idle(12);
        check_eq("hold.d0.a_rdata", 64'(if_d0.a_rdata), 64'h55);
        check_eq("hold.d1.a_rdata", 64'(if_d1.a_rdata), 64'h55);
        check_eq("hold.d0.a_rvalid", 64'(if_d0.a_rvalid), 64'h0);

        // Random traffic with an occasional reset.
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                rand_addr(), {1'($urandom_range(0, 1)), 32'($urandom())},
                1'($urandom_range(0, 1)), rand_addr());
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
